// File: rtl/clint_core_sync_if.sv
// -----------------------------------------------------------------------------
// clint_core_sync_if
//   BRAM-style access port between the TileLink-to-BRAM adapter (master) and
//   the CLINT register core (slave).
//
//   bram_en     access strobe
//   bram_we     write when high together with bram_en, read when low
//   bram_wmask  byte-lane write enables
//   bram_addr   64-bit word address (byte address >> 3)
//   bram_wdata  write data
//   bram_rdata  read data, valid the cycle after a read strobe
// -----------------------------------------------------------------------------
interface clint_core_sync_if #(
   parameter int BramAddrWidth = 13
);
   logic                     bram_en;
   logic                     bram_we;
   logic [7:0]               bram_wmask;
   logic [BramAddrWidth-1:0] bram_addr;
   logic [63:0]              bram_wdata;
   logic [63:0]              bram_rdata;

   modport master (
      output bram_en, bram_we, bram_wmask, bram_addr, bram_wdata,
      input  bram_rdata
   );

   modport slave (
      input  bram_en, bram_we, bram_wmask, bram_addr, bram_wdata,
      output bram_rdata
   );
endinterface

// File: rtl/clint_core_sync.sv
// -----------------------------------------------------------------------------
// clint_core_sync
//   Single-clock CLINT register core. Implements msip, mtimecmp and mtime
//   behind a BRAM-style port. mtime advances once every TickDivider cycles
//   of clk_i, so no separate timer clock is needed.
//
//   Word map (64-bit words):
//     h>>1          msip of hart h in 32-bit lane h[0], bit 0 only
//     0x800 + h     mtimecmp[h]
//     0x17FF        mtime
//     anything else reads 0, writes ignored
//
//   Ports:
//     clk_i   core clock
//     rst_ni  asynchronous active-low reset
//     bram    BRAM-style access port (slave side)
//     msip_o  software interrupt per hart
//     mtip_o  timer interrupt per hart (mtime >= mtimecmp, registered)
// -----------------------------------------------------------------------------
module clint_core_sync #(
   parameter int NumHarts      = 1,
   parameter int TickDivider   = 50,
   parameter int BramAddrWidth = 13
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   clint_core_sync_if.slave    bram,
   output logic [NumHarts-1:0] msip_o,
   output logic [NumHarts-1:0] mtip_o
);

   localparam int CntW = (TickDivider > 1) ? $clog2(TickDivider) : 1;
   localparam logic [CntW-1:0] TickLast = CntW'(TickDivider - 1);
   localparam logic [BramAddrWidth-1:0] MtimeAddr = BramAddrWidth'(32'h17FF);

   // Byte-lane merge: lanes with mask set take new_v, others keep old_v.
   function automatic logic [63:0] byte_merge(input logic [63:0] old_v,
                                              input logic [63:0] new_v,
                                              input logic [7:0]  mask);
      logic [63:0] bit_mask;
      bit_mask = {{8{mask[7]}}, {8{mask[6]}}, {8{mask[5]}}, {8{mask[4]}},
                  {8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
      return (new_v & bit_mask) | (old_v & ~bit_mask);
   endfunction

   logic            wr_en;
   logic            rd_en;
   logic [CntW-1:0] presc_q;
   logic            tick;
   logic [63:0]     mtime_q;
   logic [63:0]     mtime_d;
   logic [63:0]     rd_word;
   logic [63:0]     rdata_p1;
   logic [63:0]     rd_part [NumHarts];

   assign wr_en = bram.bram_en &  bram.bram_we;
   assign rd_en = bram.bram_en & ~bram.bram_we;

   // ---- prescaler / mtime --------------------------------------------------
   // The prescaler free-runs; software writes never disturb it.
   assign tick = (presc_q == TickLast);

   // A software write to mtime wins over the tick increment in the same cycle.
   always_comb begin
      mtime_d = mtime_q;
      if (wr_en && (bram.bram_addr == MtimeAddr)) begin
         mtime_d = byte_merge(mtime_q, bram.bram_wdata, bram.bram_wmask);
      end else if (tick) begin
         mtime_d = mtime_q + 64'd1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         presc_q <= '0;
         mtime_q <= '0;
      end else begin
         presc_q <= tick ? '0 : presc_q + 1'b1;
         mtime_q <= mtime_d;
      end
   end

   // ---- per-hart registers -------------------------------------------------
   for (genvar h = 0; h < NumHarts; h++) begin : g_hart
      localparam logic [BramAddrWidth-1:0] CmpAddr  = BramAddrWidth'(32'h800 + h);
      localparam logic [BramAddrWidth-1:0] MsipAddr = BramAddrWidth'(h / 2);
      localparam bit                       Lane     = (h % 2) == 1;

      logic [63:0] cmp_q;
      logic        msip_q;
      logic        mtip_p1;
      logic        lane_wen;
      logic        lane_wbit;

      // Each 32-bit msip lane is written through its byte-0 mask bit.
      assign lane_wen  = Lane ? bram.bram_wmask[4]  : bram.bram_wmask[0];
      assign lane_wbit = Lane ? bram.bram_wdata[32] : bram.bram_wdata[0];

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            cmp_q   <= '1;
            msip_q  <= 1'b0;
            mtip_p1 <= 1'b0;
         end else begin
            if (wr_en && (bram.bram_addr == CmpAddr)) begin
               cmp_q <= byte_merge(cmp_q, bram.bram_wdata, bram.bram_wmask);
            end
            if (wr_en && (bram.bram_addr == MsipAddr) && lane_wen) begin
               msip_q <= lane_wbit;
            end
            // Compare uses current register values, hence one cycle of lag.
            mtip_p1 <= (mtime_q >= cmp_q);
         end
      end

      // mtimecmp and msip addresses never overlap, so contributions can be ORed.
      assign rd_part[h] = ((bram.bram_addr == CmpAddr) ? cmp_q : 64'd0) |
                          ((bram.bram_addr == MsipAddr) ?
                              (Lane ? {31'd0, msip_q, 32'd0} : {63'd0, msip_q}) :
                              64'd0);

      assign msip_o[h] = msip_q;
      assign mtip_o[h] = mtip_p1;
   end

   // ---- read path ----------------------------------------------------------
   always_comb begin
      rd_word = (bram.bram_addr == MtimeAddr) ? mtime_q : 64'd0;
      for (int h = 0; h < NumHarts; h++) begin
         rd_word = rd_word | rd_part[h];
      end
   end

   // Read data holds its value in every cycle without a read strobe.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rdata_p1 <= '0;
      end else if (rd_en) begin
         rdata_p1 <= rd_word;
      end
   end

   assign bram.bram_rdata = rdata_p1;

endmodule

// File: tb/tb_clint_core_sync.sv
module tb_clint_core_sync;

   localparam int NH = 2;
   localparam int TD = 4;
   localparam int AW = 13;

   logic          clk   = 1'b0;
   logic          rst_n = 1'b0;
   logic [NH-1:0] msip;
   logic [NH-1:0] mtip;

   clint_core_sync_if #(.BramAddrWidth(AW)) bram_if ();

   clint_core_sync #(
      .NumHarts(NH),
      .TickDivider(TD),
      .BramAddrWidth(AW)
   ) dut (
      .clk_i (clk),
      .rst_ni(rst_n),
      .bram  (bram_if),
      .msip_o(msip),
      .mtip_o(mtip)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc_cnt = 0;
   bit mon_en = 1'b0;

   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   // reference model state
   logic [63:0]   m_mtime;
   int            m_pre;
   logic [63:0]   m_cmp [NH];
   logic [NH-1:0] m_msip;
   logic [NH-1:0] m_mtip;

   typedef struct {
      int          cyc;
      logic [12:0] addr;
      logic [63:0] val;
   } sb_t;
   sb_t sb_q[$];

   function automatic logic [63:0] merge(input logic [63:0] o, input logic [63:0] n,
                                         input logic [7:0] m);
      logic [63:0] r;
      r = o;
      for (int b = 0; b < 8; b++) begin
         if (m[b]) begin
            for (int k = 0; k < 8; k++) r[b*8+k] = n[b*8+k];
         end
      end
      return r;
   endfunction

   function automatic logic [63:0] model_read(input logic [12:0] a);
      logic [63:0] r;
      r = 64'd0;
      if (a == 13'h17FF) r = m_mtime;
      else if (a == 13'h0) r = {31'd0, m_msip[1], 31'd0, m_msip[0]};
      else begin
         for (int h = 0; h < NH; h++) begin
            if (a == 13'(32'h800 + h)) r = m_cmp[h];
         end
      end
      return r;
   endfunction

   task automatic model_reset();
      m_mtime = 64'd0;
      m_pre   = 0;
      for (int h = 0; h < NH; h++) m_cmp[h] = '1;
      m_msip  = '0;
      m_mtip  = '0;
      sb_q.delete();
   endtask

   task automatic set_idle();
      bram_if.bram_en    = 1'b0;
      bram_if.bram_we    = 1'b0;
      bram_if.bram_wmask = 8'h00;
      bram_if.bram_addr  = '0;
      bram_if.bram_wdata = 64'd0;
   endtask

   // One bus cycle: drive after a falling edge, advance the model at the rising edge.
   task automatic cyc(input logic en, input logic we, input logic [7:0] m,
                      input logic [12:0] a, input logic [63:0] d);
      logic        tick;
      logic [63:0] nt;
      bram_if.bram_en    = en;
      bram_if.bram_we    = we;
      bram_if.bram_wmask = m;
      bram_if.bram_addr  = a;
      bram_if.bram_wdata = d;
      if (en && !we) sb_q.push_back('{cyc: cyc_cnt, addr: a, val: model_read(a)});
      @(posedge clk);
      for (int h = 0; h < NH; h++) m_mtip[h] = (m_mtime >= m_cmp[h]);
      tick = (m_pre == TD - 1);
      m_pre = tick ? 0 : m_pre + 1;
      nt = tick ? m_mtime + 64'd1 : m_mtime;
      if (en && we) begin
         if (a == 13'h17FF) nt = merge(m_mtime, d, m);
         for (int h = 0; h < NH; h++) begin
            if (a == 13'(32'h800 + h)) m_cmp[h] = merge(m_cmp[h], d, m);
         end
         if (a == 13'h0) begin
            if (m[0]) m_msip[0] = d[0];
            if (m[4]) m_msip[1] = d[32];
         end
      end
      m_mtime = nt;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8'h00, 13'h0, 64'd0);
   endtask

   task automatic do_reset();
      mon_en = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      set_idle();
      model_reset();
      repeat (2) @(negedge clk);
      rst_n  = 1'b1;
      mon_en = 1'b1;
   endtask

   // scoreboard / output monitor
   always @(negedge clk) begin : mon
      sb_t e;
      if (mon_en) begin
         while (sb_q.size() > 0 && sb_q[0].cyc < cyc_cnt) begin
            e = sb_q.pop_front();
            total++;
            if (bram_if.bram_rdata !== e.val) begin
               bad++;
               $display("FAIL sb_rdata addr=%h got=%h exp=%h", e.addr, bram_if.bram_rdata, e.val);
            end
         end
         total++;
         if (msip !== m_msip) begin
            bad++;
            $display("FAIL mon_msip got=%b exp=%b", msip, m_msip);
         end
         total++;
         if (mtip !== m_mtip) begin
            bad++;
            $display("FAIL mon_mtip got=%b exp=%b", mtip, m_mtip);
         end
      end
   end

   task automatic test_reset();
      do_reset();
      total++;
      if (bram_if.bram_rdata !== 64'd0 || msip !== 2'b00 || mtip !== 2'b00) begin
         bad++;
         $display("FAIL reset_init rdata=%h msip=%b mtip=%b exp all zero",
                  bram_if.bram_rdata, msip, mtip);
      end
      cyc(1'b1, 1'b1, 8'hFF, 13'h800, 64'd0);
      cyc(1'b1, 1'b1, 8'h11, 13'h0, 64'h1_0000_0001);
      cyc(1'b1, 1'b0, 8'h00, 13'h0, 64'd0);
      idle(2);
      total++;
      if (msip !== 2'b11 || mtip[0] !== 1'b1 || bram_if.bram_rdata !== 64'h1_0000_0001) begin
         bad++;
         $display("FAIL reset_pre rdata=%h msip=%b mtip=%b exp 100000001/11/x1",
                  bram_if.bram_rdata, msip, mtip);
      end
      mon_en = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      total++;
      if (bram_if.bram_rdata !== 64'd0 || msip !== 2'b00 || mtip !== 2'b00) begin
         bad++;
         $display("FAIL reset_async rdata=%h msip=%b mtip=%b exp all zero",
                  bram_if.bram_rdata, msip, mtip);
      end
      model_reset();
      set_idle();
      @(negedge clk);
      rst_n  = 1'b1;
      mon_en = 1'b1;
      cyc(1'b1, 1'b0, 8'h00, 13'h800, 64'd0);
      total++;
      if (bram_if.bram_rdata !== 64'hFFFF_FFFF_FFFF_FFFF) begin
         bad++;
         $display("FAIL reset_cmp got=%h exp=ffffffffffffffff", bram_if.bram_rdata);
      end
      cyc(1'b1, 1'b0, 8'h00, 13'h17FF, 64'd0);
      total++;
      if (bram_if.bram_rdata !== 64'd0) begin
         bad++;
         $display("FAIL reset_mtime got=%h exp=0", bram_if.bram_rdata);
      end
   endtask

   task automatic test_msip();
      do_reset();
      cyc(1'b1, 1'b1, 8'hF0, 13'h0, 64'h1_0000_0001);
      total++;
      if (msip !== 2'b10) begin bad++; $display("FAIL msip_hi got=%b exp=10", msip); end
      cyc(1'b1, 1'b0, 8'h00, 13'h0, 64'd0);
      total++;
      if (bram_if.bram_rdata !== 64'h0000_0001_0000_0000) begin
         bad++;
         $display("FAIL msip_read got=%h exp=0000000100000000", bram_if.bram_rdata);
      end
      cyc(1'b1, 1'b1, 8'h0F, 13'h0, 64'h1);
      total++;
      if (msip !== 2'b11) begin bad++; $display("FAIL msip_lo got=%b exp=11", msip); end
      cyc(1'b1, 1'b1, 8'hEE, 13'h0, 64'd0);
      total++;
      if (msip !== 2'b11) begin bad++; $display("FAIL msip_nolane got=%b exp=11", msip); end
      cyc(1'b1, 1'b0, 8'h00, 13'h1, 64'd0);
      total++;
      if (bram_if.bram_rdata !== 64'd0) begin
         bad++;
         $display("FAIL msip_word1 got=%h exp=0", bram_if.bram_rdata);
      end
      cyc(1'b1, 1'b1, 8'h11, 13'h0, 64'd0);
      total++;
      if (msip !== 2'b00) begin bad++; $display("FAIL msip_clr got=%b exp=00", msip); end
   endtask

   task automatic test_tick();
      do_reset();
      idle(11);
      cyc(1'b1, 1'b0, 8'h00, 13'h17FF, 64'd0);
      total++;
      if (bram_if.bram_rdata !== 64'd2) begin
         bad++;
         $display("FAIL tick_c11 got=%h exp=2", bram_if.bram_rdata);
      end
      cyc(1'b1, 1'b1, 8'hFF, 13'h17FF, 64'hFFFF_FFFF_FFFF_FFFF);
      cyc(1'b1, 1'b0, 8'h00, 13'h17FF, 64'd0);
      total++;
      if (bram_if.bram_rdata !== 64'hFFFF_FFFF_FFFF_FFFF) begin
         bad++;
         $display("FAIL tick_ones got=%h exp=ffffffffffffffff", bram_if.bram_rdata);
      end
      idle(2);
      cyc(1'b1, 1'b0, 8'h00, 13'h17FF, 64'd0);
      total++;
      if (bram_if.bram_rdata !== 64'd0) begin
         bad++;
         $display("FAIL tick_wrap got=%h exp=0", bram_if.bram_rdata);
      end
   endtask

   task automatic test_mtip();
      do_reset();
      cyc(1'b1, 1'b1, 8'hFF, 13'h800, 64'd5);
      idle(19);
      total++;
      if (mtip !== 2'b00) begin bad++; $display("FAIL mtip_edgeE got=%b exp=00", mtip); end
      idle(1);
      total++;
      if (mtip !== 2'b01) begin bad++; $display("FAIL mtip_edgeE1 got=%b exp=01", mtip); end
      cyc(1'b1, 1'b1, 8'hFF, 13'h800, 64'd100);
      total++;
      if (mtip !== 2'b01) begin bad++; $display("FAIL mtip_raise1 got=%b exp=01", mtip); end
      idle(1);
      total++;
      if (mtip !== 2'b00) begin bad++; $display("FAIL mtip_raise2 got=%b exp=00", mtip); end
   endtask

   task automatic test_collision();
      do_reset();
      cyc(1'b1, 1'b1, 8'hFF, 13'h17FF, 64'h100);
      idle(2);
      cyc(1'b1, 1'b1, 8'h01, 13'h17FF, 64'hAA);
      cyc(1'b1, 1'b0, 8'h00, 13'h17FF, 64'd0);
      total++;
      if (bram_if.bram_rdata !== 64'h1AA) begin
         bad++;
         $display("FAIL coll_write got=%h exp=1aa", bram_if.bram_rdata);
      end
      idle(3);
      cyc(1'b1, 1'b0, 8'h00, 13'h17FF, 64'd0);
      total++;
      if (bram_if.bram_rdata !== 64'h1AB) begin
         bad++;
         $display("FAIL coll_next got=%h exp=1ab", bram_if.bram_rdata);
      end
   endtask

   task automatic test_partial();
      do_reset();
      cyc(1'b1, 1'b1, 8'hF0, 13'h800, 64'h1234_5678_0000_0000);
      cyc(1'b1, 1'b0, 8'h00, 13'h800, 64'd0);
      total++;
      if (bram_if.bram_rdata !== 64'h1234_5678_FFFF_FFFF) begin
         bad++;
         $display("FAIL part_cmp got=%h exp=12345678ffffffff", bram_if.bram_rdata);
      end
      cyc(1'b1, 1'b1, 8'hFF, 13'h1000, 64'hFFFF_FFFF_FFFF_FFFF);
      cyc(1'b1, 1'b1, 8'hFF, 13'h802, 64'h55);
      cyc(1'b1, 1'b0, 8'h00, 13'h1000, 64'd0);
      total++;
      if (bram_if.bram_rdata !== 64'd0) begin
         bad++;
         $display("FAIL unmapped got=%h exp=0", bram_if.bram_rdata);
      end
      bram_if.bram_en   = 1'b1;
      bram_if.bram_we   = 1'b0;
      bram_if.bram_addr = 13'h801;
      #1;
      total++;
      if (bram_if.bram_rdata !== 64'd0) begin
         bad++;
         $display("FAIL lat_early got=%h exp=0", bram_if.bram_rdata);
      end
      cyc(1'b1, 1'b0, 8'h00, 13'h801, 64'd0);
      total++;
      if (bram_if.bram_rdata !== 64'hFFFF_FFFF_FFFF_FFFF) begin
         bad++;
         $display("FAIL lat_one got=%h exp=ffffffffffffffff", bram_if.bram_rdata);
      end
      idle(1);
      cyc(1'b1, 1'b1, 8'hFF, 13'h801, 64'd7);
      total++;
      if (bram_if.bram_rdata !== 64'hFFFF_FFFF_FFFF_FFFF) begin
         bad++;
         $display("FAIL lat_hold got=%h exp=ffffffffffffffff", bram_if.bram_rdata);
      end
      cyc(1'b1, 1'b0, 8'h00, 13'h802, 64'd0);
      total++;
      if (bram_if.bram_rdata !== 64'd0) begin
         bad++;
         $display("FAIL hart2_cmp got=%h exp=0", bram_if.bram_rdata);
      end
   endtask

   task automatic test_back_to_back();
      logic [12:0] addrs [7];
      logic [12:0] a;
      logic [63:0] d;
      addrs = '{13'h0, 13'h1, 13'h800, 13'h801, 13'h802, 13'h17FF, 13'h1000};
      do_reset();
      for (int i = 0; i < 16; i++) begin
         cyc(1'b1, 1'b0, 8'h00, addrs[i % 7], 64'd0);
      end
      for (int i = 0; i < 400; i++) begin
         a = addrs[$urandom_range(0, 6)];
         if ($urandom_range(0, 1) == 0) d = 64'($urandom_range(0, 40));
         else d = {$urandom, $urandom};
         cyc(($urandom_range(0, 7) != 0), ($urandom_range(0, 2) == 0),
             8'($urandom_range(0, 255)), a, d);
      end
      idle(2);
   endtask

   initial begin
      set_idle();
      model_reset();
      test_reset();
      test_msip();
      test_tick();
      test_mtip();
      test_collision();
      test_partial();
      test_back_to_back();
      mon_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
